// File: rtl/multi_reg_sequencer_pkg.sv
// Shared definitions for the PUSH/POP multi-register sequencer.
package general_defs;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        SP_UPD
    } seq_state_e;

    localparam logic [6:0] OP_PUSH = 7'b1011010;
    localparam logic [6:0] OP_POP  = 7'b1011110;

    localparam logic [3:0] SP_ADDR = 4'd13;
    localparam logic [3:0] LR_ADDR = 4'd14;
    localparam logic [3:0] PC_ADDR = 4'd15;

    function automatic logic [3:0] popcount9(input logic [8:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/multi_reg_sequencer_lowest_set_bit_encoder.sv
// Priority encoder: index of the lowest set bit of a 9-bit register mask.
module lowest_set_bit_encoder (
    input  logic [8:0] mask_i,
    output logic [3:0] idx_o,
    output logic       found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = 4'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_reg_sequencer.sv
// Expands Thumb PUSH/POP into one transfer micro-op per register
// followed by a single SP adjust micro-op.
module multi_reg_sequencer
    import general_defs::*;
#(
    parameter int WORD       = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [15:0]           instruction_i,
    input  logic                  is_valid_i,
    input  logic                  hold_i,
    input  logic                  flush_pipeline_i,
    output logic                  uop_valid_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  addr_from_ctrl_o,
    output logic [WORD-1:0]       accumulator_imm_o,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    output logic                  reg_write_en_o,
    output logic                  sp_update_o,
    output logic                  pc_write_o,
    output logic                  stall_pipeline_o,
    output logic                  busy_o
);

    seq_state_e state_q, state_d;
    logic [8:0] mask_q, mask_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] n_q, n_d;
    logic       pop_q, pop_d;

    logic       in_push, in_pop, accept;
    logic [8:0] in_mask;
    logic [3:0] in_n;

    logic       idle;
    logic       cur_pop;
    logic [8:0] cur_mask, next_mask;
    logic [3:0] cur_idx, cur_n;
    logic [3:0] enc_idx, xfer_reg;
    logic       enc_found;
    logic [WORD-1:0] off_bytes, n_bytes, xfer_imm;
    logic       do_xfer, do_sp;

    assign in_push = instruction_i[15:9] == OP_PUSH;
    assign in_pop  = instruction_i[15:9] == OP_POP;
    assign in_mask = instruction_i[8:0];
    assign in_n    = popcount9(in_mask);
    assign accept  = is_valid_i & (in_push | in_pop) & (in_n != 4'd0)
                   & ~hold_i & ~flush_pipeline_i & ~reset_i;

    assign idle     = state_q == IDLE;
    assign busy_o   = ~idle;

    // In IDLE the first transfer is taken straight from the instruction.
    assign cur_pop  = idle ? in_pop  : pop_q;
    assign cur_mask = idle ? in_mask : mask_q;
    assign cur_idx  = idle ? 4'd0    : idx_q;
    assign cur_n    = idle ? in_n    : n_q;

    lowest_set_bit_encoder u_enc (
        .mask_i  (cur_mask),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

    assign next_mask = cur_mask & ~(9'd1 << enc_idx);
    assign xfer_reg  = (enc_idx == 4'd8) ? (cur_pop ? PC_ADDR : LR_ADDR)
                                         : enc_idx;
    assign off_bytes = WORD'({cur_idx, 2'b00});
    assign n_bytes   = WORD'({cur_n, 2'b00});
    assign xfer_imm  = cur_pop ? off_bytes : off_bytes - n_bytes;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        n_d     = n_q;
        pop_d   = pop_q;
        do_xfer = 1'b0;
        do_sp   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    do_xfer = 1'b1;
                    state_d = (in_n > 4'd1) ? XFER : SP_UPD;
                    mask_d  = next_mask;
                    idx_d   = 4'd1;
                    n_d     = in_n;
                    pop_d   = in_pop;
                end
            end
            XFER: begin
                do_xfer = enc_found;
                if (!hold_i) begin
                    mask_d = next_mask;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == n_q - 4'd1) state_d = SP_UPD;
                end
            end
            SP_UPD: begin
                do_sp = 1'b1;
                if (!hold_i) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    idx_d   = '0;
                    n_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_pipeline_i) begin
            do_xfer = 1'b0;
            do_sp   = 1'b0;
            state_d = IDLE;
            mask_d  = '0;
            idx_d   = '0;
            n_d     = '0;
        end
        if (reset_i) begin
            do_xfer = 1'b0;
            do_sp   = 1'b0;
        end
    end

    always_comb begin
        uop_valid_o       = do_xfer | do_sp;
        addr_from_ctrl_o  = do_xfer | do_sp;
        reg_addr_o        = '0;
        accumulator_imm_o = '0;
        if (do_sp) begin
            reg_addr_o        = ADDR_WIDTH'(SP_ADDR);
            accumulator_imm_o = pop_q ? n_bytes : -n_bytes;
        end else if (do_xfer) begin
            reg_addr_o        = ADDR_WIDTH'(xfer_reg);
            accumulator_imm_o = xfer_imm;
        end
        mem_write_en_o   = do_xfer & ~cur_pop;
        mem_read_en_o    = do_xfer & cur_pop;
        reg_write_en_o   = do_sp | (do_xfer & cur_pop);
        sp_update_o      = do_sp;
        pc_write_o       = do_xfer & cur_pop & (enc_idx == 4'd8);
        stall_pipeline_o = do_xfer
                         | (hold_i & busy_o & ~flush_pipeline_i & ~reset_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            pop_q   <= pop_d;
        end
    end

endmodule
